// File: rtl/inst_queue_pkg.sv
// Shared widths, NOP encoding and entry layout for the instruction queue.
// IQ_ADEF_EN adds a per-entry fetch address-error flag.
package inst_queue_pkg;

  localparam int InstWidth = 32;
  localparam int PcWidth   = 32;
  localparam logic [InstWidth-1:0] NopInst = 32'h0340_0000;
  localparam logic [PcWidth-1:0]   EmptyPc = '0;

  typedef struct packed {
`ifdef IQ_ADEF_EN
    logic                 adef;
`endif
    logic [PcWidth-1:0]   pc;
    logic [InstWidth-1:0] inst;
  } iq_entry_t;

  localparam int IqBusWidth = $bits(iq_entry_t);

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Head/tail pointers and occupancy count for the instruction queue.
// Push and pop qualification, including flush, lives here.
module iq_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [CW-1:0] count_o,
  output logic          allowin_o,
  output logic          valid_o,
  output logic          push_o
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // allowin depends only on occupancy, so a full queue never admits a push
  // even when decode drains the head in the same cycle.
  assign allowin_o = (r_count != CW'(DEPTH));
  assign valid_o   = (r_count != '0);
  assign push_o    = push_req_i && allowin_o && !flush_i;
  assign w_pop     = pop_req_i && valid_o && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push_o) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({push_o, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_head;
  assign tail_o  = r_tail;
  assign count_o = r_count;

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: entry storage and head output muxing.
// Define IQ_ADEF_EN to carry the fetch address-error flag with each entry.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 if_valid_i,
  input  logic [InstWidth-1:0] if_inst_i,
  input  logic [PcWidth-1:0]   if_pc_i,
`ifdef IQ_ADEF_EN
  input  logic                 if_adef_i,
  output logic                 iq_adef_o,
`endif
  output logic                 iq_allowin_o,
  output logic                 iq_valid_o,
  output logic [InstWidth-1:0] iq_inst_o,
  output logic [PcWidth-1:0]   iq_pc_o,
  input  logic                 id_allowin_i,
  output logic [CW-1:0]        iq_count_o
);

  logic [AW-1:0]         w_head;
  logic [AW-1:0]         w_tail;
  logic                  w_push;
  iq_entry_t             w_wr_entry;
  iq_entry_t             w_head_entry;
  logic [IqBusWidth-1:0] r_mem [DEPTH];

  iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .push_req_i (if_valid_i),
    .pop_req_i  (id_allowin_i),
    .head_o     (w_head),
    .tail_o     (w_tail),
    .count_o    (iq_count_o),
    .allowin_o  (iq_allowin_o),
    .valid_o    (iq_valid_o),
    .push_o     (w_push)
  );

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.inst = if_inst_i;
    w_wr_entry.pc   = if_pc_i;
`ifdef IQ_ADEF_EN
    w_wr_entry.adef = if_adef_i;
`endif
  end

  // Storage is not reset; emptiness is tracked purely by the pointer block.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_tail] <= w_wr_entry;
  end

  assign w_head_entry = iq_entry_t'(r_mem[w_head]);

  assign iq_inst_o = iq_valid_o ? w_head_entry.inst : NopInst;
  assign iq_pc_o   = iq_valid_o ? w_head_entry.pc   : EmptyPc;
`ifdef IQ_ADEF_EN
  assign iq_adef_o = iq_valid_o ? w_head_entry.adef : 1'b0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed, scoreboard-checked bench for inst_queue (default DEPTH=4).
// Define IQ_ADEF_EN to also exercise the address-error flag path.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          if_valid_i;
  logic [31:0]   if_inst_i;
  logic [31:0]   if_pc_i;
  logic          if_adef_i;
  logic          iq_adef_o;
  logic          iq_allowin_o;
  logic          iq_valid_o;
  logic [31:0]   iq_inst_o;
  logic [31:0]   iq_pc_o;
  logic          id_allowin_i;
  logic [CW-1:0] iq_count_o;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_popped = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .if_valid_i   (if_valid_i),
    .if_inst_i    (if_inst_i),
    .if_pc_i      (if_pc_i),
`ifdef IQ_ADEF_EN
    .if_adef_i    (if_adef_i),
    .iq_adef_o    (iq_adef_o),
`endif
    .iq_allowin_o (iq_allowin_o),
    .iq_valid_o   (iq_valid_o),
    .iq_inst_o    (iq_inst_o),
    .iq_pc_o      (iq_pc_o),
    .id_allowin_i (id_allowin_i),
    .iq_count_o   (iq_count_o)
  );

`ifndef IQ_ADEF_EN
  assign iq_adef_o = 1'b0;
`endif

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive, compare pre-edge state at negedge, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic ida,
                      input logic fl, input logic adef, output logic accepted);
    logic do_push;
    logic do_pop;
    exp_t e;
    if_valid_i   = v;
    if_pc_i      = pc;
    if_inst_i    = mk_inst(pc);
    if_adef_i    = adef;
    id_allowin_i = ida;
    flush_i      = fl;
    @(negedge clk);
    chk("count",   32'(iq_count_o),   32'(sb.size()));
    chk("valid",   32'(iq_valid_o),   32'(sb.size() != 0));
    chk("allowin", 32'(iq_allowin_o), 32'(sb.size() != DEPTH));
    if (sb.size() != 0) begin
      chk("head_inst", iq_inst_o, sb[0].inst);
      chk("head_pc",   iq_pc_o,   sb[0].pc);
`ifdef IQ_ADEF_EN
      chk("head_adef", 32'(iq_adef_o), 32'(sb[0].adef));
`endif
    end else begin
      chk("empty_inst", iq_inst_o, NOP);
      chk("empty_pc",   iq_pc_o,   32'h0);
`ifdef IQ_ADEF_EN
      chk("empty_adef", 32'(iq_adef_o), 32'h0);
`endif
    end
    do_pop   = (sb.size() != 0) && ida && !fl;
    do_push  = v && (sb.size() != DEPTH) && !fl;
    accepted = do_push;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      $display("flush");
    end else begin
      if (do_pop) begin
        $display("pop  pc=%h inst=%h", sb[0].pc, sb[0].inst);
        void'(sb.pop_front());
        n_popped++;
      end
      if (do_push) begin
        e.inst = mk_inst(pc);
        e.pc   = pc;
        e.adef = adef;
        sb.push_back(e);
        $display("push pc=%h", pc);
      end
    end
    #1;
  endtask

  initial begin
    logic acc;
    int   idx;
    int   cyc;
    rst = 1'b1; flush_i = 1'b0; if_valid_i = 1'b0; if_inst_i = '0;
    if_pc_i = '0; if_adef_i = 1'b0; id_allowin_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",   32'(iq_count_o),   32'h0);
    chk("rst_valid",   32'(iq_valid_o),   32'h0);
    chk("rst_allowin", 32'(iq_allowin_o), 32'h1);
    chk("rst_inst",    iq_inst_o,         NOP);
    chk("rst_pc",      iq_pc_o,           32'h0);
    chk("rst_adef",    32'(iq_adef_o),    32'h0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

    // Fill the queue with decode stalled.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
    chk("full_count",   32'(iq_count_o),   32'd4);
    chk("full_allowin", 32'(iq_allowin_o), 32'h0);
    chk("full_head_pc", iq_pc_o,           32'h1c00_0000);

    // Full: a concurrent push is refused, only the pop happens.
    step(1'b1, 32'h1c00_0010, 1'b1, 1'b0, 1'b0, acc);
    chk("full_push_refused", 32'(acc),        32'h0);
    chk("full_pop_count",    32'(iq_count_o), 32'd3);
    chk("full_pop_head_pc",  iq_pc_o,         32'h1c00_0004);

    // Count 2, then simultaneous push and pop.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("cnt2_count", 32'(iq_count_o), 32'd2);
    step(1'b1, 32'h1c00_0020, 1'b1, 1'b0, 1'b0, acc);
    chk("pushpop_count",   32'(iq_count_o), 32'd2);
    chk("pushpop_head_pc", iq_pc_o,         32'h1c00_000c);

    // Count 3, flush with a push offered.
    step(1'b1, 32'h1c00_0024, 1'b0, 1'b0, 1'b0, acc);
    chk("preflush_count", 32'(iq_count_o), 32'd3);
    step(1'b1, 32'h1c00_0028, 1'b0, 1'b1, 1'b0, acc);
    chk("flush_count", 32'(iq_count_o), 32'd0);
    chk("flush_valid", 32'(iq_valid_o), 32'h0);
    chk("flush_inst",  iq_inst_o,       NOP);
    chk("flush_pc",    iq_pc_o,         32'h0);

    // Stream 10 instructions through with decode toggling; wraps the pointers.
    n_popped = 0;
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 200) begin
      step(1'b1, 32'h1c00_0100 + 32'(4 * idx), 1'(cyc % 2), 1'b0, 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("stream_all_pushed", 32'(idx), 32'd10);
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      cyc++;
    end
    chk("stream_popped", 32'(n_popped), 32'd10);
    chk("stream_drained_count", 32'(iq_count_o), 32'd0);

    // Asynchronous reset mid-cycle with entries held.
    step(1'b1, 32'h1c00_0200, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1c00_0204, 1'b0, 1'b0, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    chk("arst_count",   32'(iq_count_o),   32'h0);
    chk("arst_valid",   32'(iq_valid_o),   32'h0);
    chk("arst_allowin", 32'(iq_allowin_o), 32'h1);
    chk("arst_inst",    iq_inst_o,         NOP);
    chk("arst_pc",      iq_pc_o,           32'h0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);

`ifdef IQ_ADEF_EN
    step(1'b1, 32'h1c00_0300, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 32'h1c00_0304, 1'b0, 1'b0, 1'b0, acc);
    chk("adef_first", 32'(iq_adef_o), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("adef_second", 32'(iq_adef_o), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("adef_empty", 32'(iq_adef_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
